// File: rtl/idu_is_pipe0_iq_pkg.sv
// Shared widths, the issue-queue entry layout and the wakeup match helper
// used by the pipe0 issue queue.
package idu_is_pipe0_iq_pkg;
  localparam int PREG_W = 6;
  localparam int IID_W  = 4;
  localparam int XLEN   = 64;
  localparam int WK_N   = 4;

  typedef struct packed {
    logic [IID_W-1:0]  iid;
    logic [6:0]        opcode;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   pc;
    logic              psrc1_vld;
    logic [PREG_W-1:0] psrc1;
    logic              psrc1_rdy;
    logic              psrc2_vld;
    logic [PREG_W-1:0] psrc2;
    logic              psrc2_rdy;
    logic              pdst_vld;
    logic [PREG_W-1:0] pdst;
    logic              imm_vld;
    logic [XLEN-1:0]   imm;
  } iq_ent_t;

  localparam int ENT_W = $bits(iq_ent_t);

  function automatic logic wk_hit(input logic [WK_N-1:0] vld,
                                  input logic [WK_N-1:0][PREG_W-1:0] preg,
                                  input logic [PREG_W-1:0] src);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WK_N; w++)
      hit |= vld[w] & (preg[w] == src);
    return hit;
  endfunction
endpackage

// File: rtl/idu_is_pipe0_iq_entry.sv
// One issue-queue slot: holds, shifts in from the slot above or loads the
// dispatched instr, and snoops every wakeup port on whatever it ends up holding.
module idu_is_pipe0_iq_entry
  import idu_is_pipe0_iq_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_clk,
  input  logic                         flush,
  input  logic                         load,
  input  logic [ENT_W-1:0]             load_data,
  input  logic                         shift,
  input  logic                         shift_vld,
  input  logic [ENT_W-1:0]             shift_data,
  input  logic [WK_N-1:0]              wk_vld,
  input  logic [WK_N-1:0][PREG_W-1:0]  wk_preg,
  output logic                         vld,
  output logic [ENT_W-1:0]             data,
  output logic                         rdy
);
  iq_ent_t cur_q, nxt;
  logic    vld_q, nxt_vld;

  // Wakeup is applied after the source mux so shifted and newly loaded
  // instrs never miss a broadcast from the cycle they move.
  always_comb begin
    nxt     = cur_q;
    nxt_vld = vld_q;
    if (load) begin
      nxt     = iq_ent_t'(load_data);
      nxt_vld = 1'b1;
    end else if (shift) begin
      nxt     = iq_ent_t'(shift_data);
      nxt_vld = shift_vld;
    end
    nxt.psrc1_rdy = nxt.psrc1_rdy | wk_hit(wk_vld, wk_preg, nxt.psrc1);
    nxt.psrc2_rdy = nxt.psrc2_rdy | wk_hit(wk_vld, wk_preg, nxt.psrc2);
    if (flush) nxt_vld = 1'b0;
  end

  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      vld_q <= 1'b0;
      cur_q <= '0;
    end else begin
      vld_q <= nxt_vld;
      cur_q <= nxt;
    end
  end

  assign vld  = vld_q;
  assign data = cur_q;
  assign rdy  = vld_q & (~cur_q.psrc1_vld | cur_q.psrc1_rdy)
                      & (~cur_q.psrc2_vld | cur_q.psrc2_rdy);
endmodule

// File: rtl/idu_is_pipe0_iq.sv
// Pipe0 collapsing issue queue: oldest-ready select, one issue per cycle,
// entries shift down over the issued slot.
module idu_is_pipe0_iq
  import idu_is_pipe0_iq_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              rtu_global_flush,
  input  logic              dp_idu_is_pipe0_vld,
  input  logic [IID_W-1:0]  dp_idu_is_pipe0_iid,
  input  logic [6:0]        dp_idu_is_pipe0_opcode,
  input  logic [6:0]        dp_idu_is_pipe0_funct7,
  input  logic [2:0]        dp_idu_is_pipe0_funct3,
  input  logic [XLEN-1:0]   dp_idu_is_pipe0_pc,
  input  logic [XLEN-1:0]   dp_idu_is_pipe0_imm,
  input  logic [PREG_W-1:0] dp_idu_is_pipe0_psrc1,
  input  logic [PREG_W-1:0] dp_idu_is_pipe0_psrc2,
  input  logic [PREG_W-1:0] dp_idu_is_pipe0_pdst,
  input  logic              dp_idu_is_pipe0_psrc1_vld,
  input  logic              dp_idu_is_pipe0_psrc2_vld,
  input  logic              dp_idu_is_pipe0_pdst_vld,
  input  logic              dp_idu_is_pipe0_imm_vld,
  input  logic              dp_idu_is_pipe0_psrc1_rdy,
  input  logic              dp_idu_is_pipe0_psrc2_rdy,
  output logic              idu_dp_is_pipe0_full,
  output logic [CNT_W-1:0]  idu_dp_is_pipe0_cnt,
  input  logic              idu_idu_is_alu_rf_forward_vld,
  input  logic [PREG_W-1:0] idu_idu_is_alu_rf_forward_preg,
  input  logic              exu_idu_is_mxu_cdb_vld,
  input  logic [PREG_W-1:0] exu_idu_is_mxu_cdb_preg,
  input  logic              exu_idu_is_div_cdb_vld,
  input  logic [PREG_W-1:0] exu_idu_is_div_cdb_preg,
  input  logic              exu_idu_is_lsu_cdb_vld,
  input  logic [PREG_W-1:0] exu_idu_is_lsu_cdb_preg,
  output logic              idu_idu_rf_pipe0_vld,
  output logic [IID_W-1:0]  idu_idu_rf_pipe0_iid,
  output logic [6:0]        idu_idu_rf_pipe0_opcode,
  output logic [6:0]        idu_idu_rf_pipe0_funct7,
  output logic [2:0]        idu_idu_rf_pipe0_funct3,
  output logic [XLEN-1:0]   idu_idu_rf_pipe0_pc,
  output logic              idu_idu_rf_pipe0_psrc1_vld,
  output logic [PREG_W-1:0] idu_idu_rf_pipe0_psrc1,
  output logic              idu_idu_rf_pipe0_psrc2_vld,
  output logic [PREG_W-1:0] idu_idu_rf_pipe0_psrc2,
  output logic              idu_idu_rf_pipe0_pdst_vld,
  output logic [PREG_W-1:0] idu_idu_rf_pipe0_pdst,
  output logic              idu_idu_rf_pipe0_imm_vld,
  output logic [XLEN-1:0]   idu_idu_rf_pipe0_imm
);
  logic [WK_N-1:0]             wk_vld;
  logic [WK_N-1:0][PREG_W-1:0] wk_preg;
  logic [DEPTH-1:0]            ent_vld, ent_rdy, ent_load, ent_shift;
  logic [DEPTH-1:0][ENT_W-1:0] ent_data;
  logic [CNT_W-1:0]            cnt_q, enq_idx;
  logic [SEL_W-1:0]            sel;
  logic                        full, enq_ok, iss;
  iq_ent_t                     enq_ent, iss_ent;

  assign wk_vld  = {exu_idu_is_lsu_cdb_vld, exu_idu_is_div_cdb_vld,
                    exu_idu_is_mxu_cdb_vld, idu_idu_is_alu_rf_forward_vld};
  assign wk_preg = {exu_idu_is_lsu_cdb_preg, exu_idu_is_div_cdb_preg,
                    exu_idu_is_mxu_cdb_preg, idu_idu_is_alu_rf_forward_preg};

  always_comb begin
    enq_ent           = '0;
    enq_ent.iid       = dp_idu_is_pipe0_iid;
    enq_ent.opcode    = dp_idu_is_pipe0_opcode;
    enq_ent.funct7    = dp_idu_is_pipe0_funct7;
    enq_ent.funct3    = dp_idu_is_pipe0_funct3;
    enq_ent.pc        = dp_idu_is_pipe0_pc;
    enq_ent.psrc1_vld = dp_idu_is_pipe0_psrc1_vld;
    enq_ent.psrc1     = dp_idu_is_pipe0_psrc1;
    enq_ent.psrc1_rdy = dp_idu_is_pipe0_psrc1_rdy;
    enq_ent.psrc2_vld = dp_idu_is_pipe0_psrc2_vld;
    enq_ent.psrc2     = dp_idu_is_pipe0_psrc2;
    enq_ent.psrc2_rdy = dp_idu_is_pipe0_psrc2_rdy;
    enq_ent.pdst_vld  = dp_idu_is_pipe0_pdst_vld;
    enq_ent.pdst      = dp_idu_is_pipe0_pdst;
    enq_ent.imm_vld   = dp_idu_is_pipe0_imm_vld;
    enq_ent.imm       = dp_idu_is_pipe0_imm;
  end

  // Lowest index wins: scan high to low so the last hit is the oldest.
  always_comb begin
    sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (ent_rdy[i]) sel = SEL_W'(i);
  end

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign iss     = (|ent_rdy) & ~rtu_global_flush;
  assign enq_ok  = dp_idu_is_pipe0_vld & ~full & ~rtu_global_flush;
  assign enq_idx = cnt_q - CNT_W'(iss);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic             up_vld;
    logic [ENT_W-1:0] up_data;
    if (i == DEPTH - 1) begin : g_top
      assign up_vld  = 1'b0;
      assign up_data = '0;
    end else begin : g_mid
      assign up_vld  = ent_vld[i+1];
      assign up_data = ent_data[i+1];
    end
    assign ent_load[i]  = enq_ok & (enq_idx == CNT_W'(i));
    assign ent_shift[i] = iss & (SEL_W'(i) >= sel);

    idu_is_pipe0_iq_entry u_ent (
      .clk        (clk),
      .rst_clk    (rst_clk),
      .flush      (rtu_global_flush),
      .load       (ent_load[i]),
      .load_data  (enq_ent),
      .shift      (ent_shift[i]),
      .shift_vld  (up_vld),
      .shift_data (up_data),
      .wk_vld     (wk_vld),
      .wk_preg    (wk_preg),
      .vld        (ent_vld[i]),
      .data       (ent_data[i]),
      .rdy        (ent_rdy[i])
    );
  end

  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk)               cnt_q <= '0;
    else if (rtu_global_flush) cnt_q <= '0;
    else                       cnt_q <= cnt_q + CNT_W'(enq_ok) - CNT_W'(iss);
  end

  assign idu_dp_is_pipe0_full = full;
  assign idu_dp_is_pipe0_cnt  = cnt_q;

  assign iss_ent = iss ? iq_ent_t'(ent_data[sel]) : '0;

  assign idu_idu_rf_pipe0_vld       = iss;
  assign idu_idu_rf_pipe0_iid       = iss_ent.iid;
  assign idu_idu_rf_pipe0_opcode    = iss_ent.opcode;
  assign idu_idu_rf_pipe0_funct7    = iss_ent.funct7;
  assign idu_idu_rf_pipe0_funct3    = iss_ent.funct3;
  assign idu_idu_rf_pipe0_pc        = iss_ent.pc;
  assign idu_idu_rf_pipe0_psrc1_vld = iss_ent.psrc1_vld;
  assign idu_idu_rf_pipe0_psrc1     = iss_ent.psrc1;
  assign idu_idu_rf_pipe0_psrc2_vld = iss_ent.psrc2_vld;
  assign idu_idu_rf_pipe0_psrc2     = iss_ent.psrc2;
  assign idu_idu_rf_pipe0_pdst_vld  = iss_ent.pdst_vld;
  assign idu_idu_rf_pipe0_pdst      = iss_ent.pdst;
  assign idu_idu_rf_pipe0_imm_vld   = iss_ent.imm_vld;
  assign idu_idu_rf_pipe0_imm       = iss_ent.imm;
endmodule

// File: tb/tb_idu_is_pipe0_iq.sv
// Directed bench for the pipe0 issue queue: latency, wakeup paths,
// full/drop, flush priority and async reset.
module tb_idu_is_pipe0_iq;
  logic        clk = 1'b0, rst_clk = 1'b1, flush = 1'b0;
  logic        dp_vld, dp_s1v, dp_s2v, dp_pdv, dp_immv, dp_s1r, dp_s2r;
  logic [3:0]  dp_iid;
  logic [6:0]  dp_op, dp_f7;
  logic [2:0]  dp_f3;
  logic [63:0] dp_pc, dp_imm;
  logic [5:0]  dp_p1, dp_p2, dp_pd;
  logic        alu_v, mxu_v, div_v, lsu_v;
  logic [5:0]  alu_p, mxu_p, div_p, lsu_p;
  logic        full, o_vld, o_s1v, o_s2v, o_pdv, o_immv;
  logic [3:0]  cnt, o_iid;
  logic [6:0]  o_op, o_f7;
  logic [2:0]  o_f3;
  logic [63:0] o_pc, o_imm;
  logic [5:0]  o_p1, o_p2, o_pd;
  int          nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  idu_is_pipe0_iq dut (
    .clk(clk), .rst_clk(rst_clk), .rtu_global_flush(flush),
    .dp_idu_is_pipe0_vld(dp_vld), .dp_idu_is_pipe0_iid(dp_iid),
    .dp_idu_is_pipe0_opcode(dp_op), .dp_idu_is_pipe0_funct7(dp_f7),
    .dp_idu_is_pipe0_funct3(dp_f3), .dp_idu_is_pipe0_pc(dp_pc),
    .dp_idu_is_pipe0_imm(dp_imm), .dp_idu_is_pipe0_psrc1(dp_p1),
    .dp_idu_is_pipe0_psrc2(dp_p2), .dp_idu_is_pipe0_pdst(dp_pd),
    .dp_idu_is_pipe0_psrc1_vld(dp_s1v), .dp_idu_is_pipe0_psrc2_vld(dp_s2v),
    .dp_idu_is_pipe0_pdst_vld(dp_pdv), .dp_idu_is_pipe0_imm_vld(dp_immv),
    .dp_idu_is_pipe0_psrc1_rdy(dp_s1r), .dp_idu_is_pipe0_psrc2_rdy(dp_s2r),
    .idu_dp_is_pipe0_full(full), .idu_dp_is_pipe0_cnt(cnt),
    .idu_idu_is_alu_rf_forward_vld(alu_v), .idu_idu_is_alu_rf_forward_preg(alu_p),
    .exu_idu_is_mxu_cdb_vld(mxu_v), .exu_idu_is_mxu_cdb_preg(mxu_p),
    .exu_idu_is_div_cdb_vld(div_v), .exu_idu_is_div_cdb_preg(div_p),
    .exu_idu_is_lsu_cdb_vld(lsu_v), .exu_idu_is_lsu_cdb_preg(lsu_p),
    .idu_idu_rf_pipe0_vld(o_vld), .idu_idu_rf_pipe0_iid(o_iid),
    .idu_idu_rf_pipe0_opcode(o_op), .idu_idu_rf_pipe0_funct7(o_f7),
    .idu_idu_rf_pipe0_funct3(o_f3), .idu_idu_rf_pipe0_pc(o_pc),
    .idu_idu_rf_pipe0_psrc1_vld(o_s1v), .idu_idu_rf_pipe0_psrc1(o_p1),
    .idu_idu_rf_pipe0_psrc2_vld(o_s2v), .idu_idu_rf_pipe0_psrc2(o_p2),
    .idu_idu_rf_pipe0_pdst_vld(o_pdv), .idu_idu_rf_pipe0_pdst(o_pd),
    .idu_idu_rf_pipe0_imm_vld(o_immv), .idu_idu_rf_pipe0_imm(o_imm)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    dp_vld = 0; dp_iid = 0; dp_op = 0; dp_f7 = 0; dp_f3 = 0; dp_pc = 0; dp_imm = 0;
    dp_p1 = 0; dp_p2 = 0; dp_pd = 0; dp_s1v = 0; dp_s2v = 0; dp_pdv = 0; dp_immv = 0;
    dp_s1r = 0; dp_s2r = 0; flush = 0;
    alu_v = 0; mxu_v = 0; div_v = 0; lsu_v = 0;
    alu_p = 0; mxu_p = 0; div_p = 0; lsu_p = 0;
  endtask

  // Advance one cycle; inputs go back to idle just after the edge.
  task automatic tick();
    @(posedge clk); #1; idle();
  endtask

  task automatic enq(input logic [3:0] iid, input logic s1v, input logic s1r, input logic [5:0] p1,
                     input logic s2v, input logic s2r, input logic [5:0] p2);
    dp_vld = 1; dp_iid = iid; dp_op = 7'h33; dp_f7 = 7'h20; dp_f3 = iid[2:0];
    dp_pc = 64'h8000_0000 + 64'(iid) * 4; dp_imm = 64'h100 + 64'(iid);
    dp_pd = 6'h30 + 6'(iid); dp_pdv = 1; dp_immv = 1;
    dp_s1v = s1v; dp_s1r = s1r; dp_p1 = p1; dp_s2v = s2v; dp_s2r = s2r; dp_p2 = p2;
  endtask

  initial begin
    idle();
    #1 chk("rst_vld", o_vld, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_full", full, 0);
    @(posedge clk); #1 rst_clk = 0;

    // Ready at dispatch: visible the next cycle, gone the one after.
    enq(3, 1, 1, 6'h01, 1, 1, 6'h02);
    #1 chk("t2_enq_cyc_vld", o_vld, 0);
    tick(); #1;
    chk("t2_vld", o_vld, 1);
    chk("t2_iid", o_iid, 3);
    chk("t2_pc", o_pc, 64'h8000_000C);
    chk("t2_pdst", o_pd, 6'h33);
    chk("t2_cnt", cnt, 1);
    tick(); #1;
    chk("t2_drain_vld", o_vld, 0);
    chk("t2_drain_cnt", cnt, 0);

    // Older waiting instr is bypassed by a younger ready one, then woken by MXU.
    enq(1, 1, 0, 6'h12, 0, 0, 6'h00);
    tick();
    enq(2, 0, 0, 6'h00, 0, 0, 6'h00);
    #1 chk("t3_wait_vld", o_vld, 0);
    tick();
    mxu_v = 1; mxu_p = 6'h12;
    #1 chk("t3_first_iid", o_iid, 2);
    chk("t3_first_cnt", cnt, 2);
    tick(); #1;
    chk("t3_second_vld", o_vld, 1);
    chk("t3_second_iid", o_iid, 1);
    chk("t3_second_p1", o_p1, 6'h12);
    tick(); #1;
    chk("t3_empty_cnt", cnt, 0);

    // ALU forward in the dispatch cycle wakes the incoming instr.
    enq(4, 0, 0, 6'h00, 1, 0, 6'h05);
    alu_v = 1; alu_p = 6'h05;
    #1 chk("t4_same_cyc_vld", o_vld, 0);
    tick(); #1;
    chk("t4_vld", o_vld, 1);
    chk("t4_iid", o_iid, 4);
    chk("t4_p2", o_p2, 6'h05);
    tick();

    // Fill with non-ready instrs; an enqueue while full is dropped.
    for (int i = 0; i < 8; i++) begin
      enq(4'(i), 1, 0, 6'h20 + 6'(i), 0, 0, 6'h00);
      tick();
    end
    #1 chk("t5_cnt_full", cnt, 8);
    chk("t5_full", full, 1);
    chk("t5_none_rdy", o_vld, 0);
    enq(9, 0, 0, 6'h00, 0, 0, 6'h00);
    div_v = 1; div_p = 6'h20;
    lsu_v = 1; lsu_p = 6'h3F;
    tick(); #1;
    chk("t5_wake_vld", o_vld, 1);
    chk("t5_wake_iid", o_iid, 0);
    chk("t5_drop_cnt", cnt, 8);
    tick(); #1;
    chk("t5_after_cnt", cnt, 7);
    chk("t5_after_full", full, 0);
    chk("t5_after_vld", o_vld, 0);

    // Two wakeups in one cycle, then trim to 5 entries.
    mxu_v = 1; mxu_p = 6'h21;
    div_v = 1; div_p = 6'h22;
    tick(); #1;
    chk("t6_iss1_iid", o_iid, 1);
    tick(); #1;
    chk("t6_iss2_iid", o_iid, 2);
    chk("t6_iss2_cnt", cnt, 6);
    tick();
    alu_v = 1; alu_p = 6'h23;
    #1 chk("t6_five_cnt", cnt, 5);
    tick();
    // Head is ready here; flush still suppresses issue and enqueue.
    flush = 1;
    enq(10, 0, 0, 6'h00, 0, 0, 6'h00);
    lsu_v = 1; lsu_p = 6'h24;
    #1 chk("t6_flush_vld", o_vld, 0);
    chk("t6_flush_iid", o_iid, 0);
    tick(); #1;
    chk("t6_post_cnt", cnt, 0);
    chk("t6_post_vld", o_vld, 0);
    tick(); #1;
    chk("t6_no_enq_vld", o_vld, 0);

    // Async reset in the middle of traffic.
    enq(5, 0, 0, 6'h00, 0, 0, 6'h00);
    tick();
    enq(6, 1, 0, 6'h11, 0, 0, 6'h00);
    #1 chk("t1_pre_vld", o_vld, 1);
    rst_clk = 1;
    #1 chk("t1_rst_vld", o_vld, 0);
    chk("t1_rst_cnt", cnt, 0);
    chk("t1_rst_full", full, 0);
    chk("t1_rst_iid", o_iid, 0);
    chk("t1_rst_pc", o_pc, 0);
    chk("t1_rst_imm", o_imm, 0);
    tick();
    rst_clk = 0;
    tick(); #1;
    chk("t1_post_cnt", cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
